// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC host sequencer and its response FIFO.
package cordic_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    localparam logic CORDIC_MODE_ROT = 1'b0;
    localparam logic CORDIC_MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] x;
        logic [DEFAULT_DATA_W-1:0] y;
        logic                      mode;
        logic                      tmo;
    } rsp_entry_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Two-entry registered response FIFO; slot0 is the head and drives the response port directly.
module cordic_rsp_fifo
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clka,
    input  logic       reset_n,
    input  logic       push,
    input  rsp_entry_t push_entry,
    input  logic       pop,
    output rsp_entry_t head,
    output logic [1:0] count
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("cordic_rsp_fifo supports exactly two entries");
    end

    rsp_entry_t slot0_r, slot1_r;
    rsp_entry_t slot0_s, slot1_s;
    logic [1:0] count_r, count_s;
    logic       pop_s;

    // Next-state of the two slots and the occupancy count.
    always_comb begin
        pop_s   = pop && (count_r != 2'd0);
        slot0_s = slot0_r;
        slot1_s = slot1_r;
        count_s = count_r;
        case (count_r)
            2'd0: begin
                if (push) begin
                    slot0_s = push_entry;
                    count_s = 2'd1;
                end else begin
                    count_s = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop_s) begin
                    slot0_s = push_entry;
                end else if (push) begin
                    slot1_s = push_entry;
                    count_s = 2'd2;
                end else if (pop_s) begin
                    count_s = 2'd0;
                end else begin
                    count_s = 2'd1;
                end
            end
            2'd2: begin
                // A push without a free slot cannot arrive; it would be dropped here.
                if (pop_s) begin
                    slot0_s = slot1_r;
                    if (push) begin
                        slot1_s = push_entry;
                    end else begin
                        count_s = 2'd1;
                    end
                end else begin
                    count_s = 2'd2;
                end
            end
            default: begin
                count_s = 2'd0;
            end
        endcase
    end

    // Slot and count registers.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            slot0_r <= slot0_s;
            slot1_r <= slot1_s;
            count_r <= count_s;
        end
    end

    assign head  = slot0_r;
    assign count = count_r;

endmodule

// File: rtl/cordic_host_sequencer.sv
// Host-side initiator for the CORDIC core: accepts one job at a time, issues it,
// waits for a done edge or a timeout, and queues the result in a 2-entry FIFO.
module cordic_host_sequencer
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic              clka,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              core_start,
    output logic              core_mode,
    output logic [DATA_W-1:0] core_port0,
    output logic [DATA_W-1:0] core_port1,
    input  logic [DATA_W-1:0] core_out0,
    input  logic [DATA_W-1:0] core_out1,
    input  logic              core_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_x,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_mode,
    output logic              rsp_tmo
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    // The response entry layout is fixed by the package width.
    if (DATA_W != DEFAULT_DATA_W) begin : g_bad_width
        $error("DATA_W must match cordic_pkg::DEFAULT_DATA_W");
    end

    seq_state_t        state_r, state_s;
    logic [TIMER_W-1:0] timer_r;
    logic              done_prev_r;
    logic              mode_r;
    logic [DATA_W-1:0] port0_r, port1_r;
    logic              core_start_r;
    logic              req_ready_r;

    logic              accept_s, edge_s, timeout_s, push_s, pop_s, ready_next_s;
    rsp_entry_t        push_entry_s, head_s;
    logic [1:0]        fifo_count_s, count_next_s;

    // Sequencer next-state, completion detection and FIFO push decision.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        push_s       = 1'b0;
        push_entry_s = '0;
        edge_s       = core_done && !done_prev_r;
        timeout_s    = (timer_r == TIMER_LAST);
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                // A done edge on the timeout cycle still counts as a completion.
                if (edge_s) begin
                    push_s            = 1'b1;
                    push_entry_s.x    = core_out0;
                    push_entry_s.y    = core_out1;
                    push_entry_s.mode = mode_r;
                    push_entry_s.tmo  = 1'b0;
                    state_s           = IDLE;
                end else if (timeout_s) begin
                    push_s            = 1'b1;
                    push_entry_s.mode = mode_r;
                    push_entry_s.tmo  = 1'b1;
                    state_s           = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's push/pop, used to register req_ready one cycle ahead.
    always_comb begin
        pop_s = rsp_valid && rsp_ready;
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + 2'd1;
            2'b01:   count_next_s = fifo_count_s - 2'd1;
            default: count_next_s = fifo_count_s;
        endcase
        ready_next_s = (state_s == IDLE) && (count_next_s < 2'd2);
    end

    // State register.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake outputs, operand holding registers, done history and timeout timer.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            core_start_r <= 1'b0;
            req_ready_r  <= 1'b0;
            mode_r       <= 1'b0;
            port0_r      <= {DATA_W{1'b0}};
            port1_r      <= {DATA_W{1'b0}};
            done_prev_r  <= 1'b0;
            timer_r      <= {TIMER_W{1'b0}};
        end else begin
            core_start_r <= accept_s;
            req_ready_r  <= ready_next_s;
            if (accept_s) begin
                mode_r  <= req_mode;
                port0_r <= req_a;
                port1_r <= req_b;
            end
            if (state_r == ISSUE) begin
                // Sampling done here makes a level left over from the last job look stale.
                done_prev_r <= core_done;
                timer_r     <= {TIMER_W{1'b0}};
            end else if (state_r == WAIT) begin
                done_prev_r <= core_done;
                if (timer_r != TIMER_LAST) begin
                    timer_r <= timer_r + TIMER_W'(1);
                end
            end
        end
    end

    cordic_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clka       (clka),
        .reset_n    (reset_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (fifo_count_s)
    );

    assign req_ready  = req_ready_r;
    assign core_start = core_start_r;
    assign core_mode  = mode_r;
    assign core_port0 = port0_r;
    assign core_port1 = port1_r;
    assign rsp_valid  = (fifo_count_s != 2'd0);
    assign rsp_x      = head_s.x;
    assign rsp_y      = head_s.y;
    assign rsp_mode   = head_s.mode;
    assign rsp_tmo    = head_s.tmo;

endmodule

// File: tb/tb_cordic_host_sequencer.sv
// Directed bench for cordic_host_sequencer with a behavioural CORDIC core model
// whose done delay, result values and done style are set per job.
module tb_cordic_host_sequencer;
    import cordic_pkg::*;

    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 32;

    logic              clka = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_mode = 1'b0;
    logic [DATA_W-1:0] req_a = 8'h00;
    logic [DATA_W-1:0] req_b = 8'h00;
    logic              core_start;
    logic              core_mode;
    logic [DATA_W-1:0] core_port0, core_port1;
    logic [DATA_W-1:0] core_out0, core_out1;
    logic              core_done;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_x, rsp_y;
    logic              rsp_mode, rsp_tmo;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int base;
    int lat;

    // core model knobs
    int              m_delay = 12;
    logic [7:0]      m_out0 = 8'h00;
    logic [7:0]      m_out1 = 8'h00;
    bit              m_never = 1'b0;
    bit              m_keep = 1'b0;
    int              m_cnt = 0;
    bit              m_active = 1'b0;

    always #5 clka = ~clka;

    cordic_host_sequencer #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (2)
    ) dut (
        .clka       (clka),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_a      (req_a),
        .req_b      (req_b),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_port0 (core_port0),
        .core_port1 (core_port1),
        .core_out0  (core_out0),
        .core_out1  (core_out1),
        .core_done  (core_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_x      (rsp_x),
        .rsp_y      (rsp_y),
        .rsp_mode   (rsp_mode),
        .rsp_tmo    (rsp_tmo)
    );

    // Behavioural core: done rises m_delay negedges after the start pulse is seen.
    // With m_keep the previous done level stays high and drops 5 cycles before the new edge.
    initial begin
        core_done = 1'b0;
        core_out0 = 8'h00;
        core_out1 = 8'h00;
        forever begin
            @(negedge clka);
            if (!reset_n) begin
                m_active  = 1'b0;
                core_done = 1'b0;
            end else if (core_start) begin
                m_cnt    = m_delay;
                m_active = 1'b1;
                if (!m_keep) core_done = 1'b0;
            end else if (m_active) begin
                m_cnt = m_cnt - 1;
                if (m_keep && m_cnt == 5) core_done = 1'b0;
                if (m_cnt == 0) begin
                    m_active = 1'b0;
                    if (!m_never) begin
                        core_done = 1'b1;
                        core_out0 = m_out0;
                        core_out1 = m_out1;
                    end
                end
            end
        end
    end

    always @(negedge clka) begin
        if (core_start) start_cnt = start_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    // Presents a job and returns 1 time unit after the accepting edge.
    task automatic send_job(input logic m, input logic [7:0] a, input logic [7:0] b);
        int n;
        req_valid = 1'b1;
        req_mode  = m;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clka);
            #1;
            n++;
        end
        check_eq("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        check_eq("core_start_after_accept", {31'd0, core_start}, 32'd1);
        check_eq("core_mode_latched", {31'd0, core_mode}, {31'd0, m});
        check_eq("core_port0_latched", {24'd0, core_port0}, {24'd0, a});
        check_eq("core_port1_latched", {24'd0, core_port1}, {24'd0, b});
    endtask

    // Counts edges until rsp_valid is seen.
    task automatic wait_rsp(output int edges);
        edges = 0;
        do begin
            @(posedge clka);
            #1;
            edges++;
        end while (!rsp_valid && edges < 100);
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        @(posedge clka);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic m, input logic t);
        check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_x"}, {24'd0, rsp_x}, {24'd0, x});
        check_eq({tag, "_y"}, {24'd0, rsp_y}, {24'd0, y});
        check_eq({tag, "_mode"}, {31'd0, rsp_mode}, {31'd0, m});
        check_eq({tag, "_tmo"}, {31'd0, rsp_tmo}, {31'd0, t});
    endtask

    initial begin
        // reset state
        wait_cycles(2);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_core_start", {31'd0, core_start}, 32'd0);
        @(negedge clka);
        reset_n = 1'b1;
        @(posedge clka);
        #1;
        check_eq("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // rotation job, done 12 cycles after start
        m_delay = 12; m_out0 = 8'h26; m_out1 = 8'h1F;
        base = start_cnt;
        send_job(CORDIC_MODE_ROT, 8'h40, 8'h00);
        wait_cycles(1);
        check_eq("t2_start_dropped", {31'd0, core_start}, 32'd0);
        check_eq("t2_port0_held", {24'd0, core_port0}, 32'h40);
        check_eq("t2_req_ready_busy", {31'd0, req_ready}, 32'd0);
        wait_rsp(lat);
        check_eq("t2_latency", lat, 32'd12);  // 13 edges from accept, one already consumed
        check_rsp("t2", 8'h26, 8'h1F, CORDIC_MODE_ROT, 1'b0);
        check_eq("t2_start_pulses", start_cnt - base, 32'd1);
        pop_rsp();
        check_eq("t2_empty", {31'd0, rsp_valid}, 32'd0);

        // stale done level from the previous job must be ignored
        m_keep = 1'b1; m_delay = 10; m_out0 = 8'h5A; m_out1 = 8'h20;
        send_job(CORDIC_MODE_VEC, 8'h40, 8'h40);
        wait_rsp(lat);
        check_eq("t3_latency", lat, 32'd11);
        check_rsp("t3", 8'h5A, 8'h20, CORDIC_MODE_VEC, 1'b0);
        pop_rsp();
        m_keep = 1'b0;

        // three back-to-back jobs with the consumer stalled
        m_delay = 4; m_out0 = 8'h11; m_out1 = 8'h12;
        send_job(CORDIC_MODE_ROT, 8'h01, 8'h01);
        wait_rsp(lat);
        check_eq("t4_a_latency", lat, 32'd5);
        m_out0 = 8'h21; m_out1 = 8'h22;
        send_job(CORDIC_MODE_VEC, 8'h02, 8'h02);
        wait_cycles(5);
        check_eq("t4_full_req_ready", {31'd0, req_ready}, 32'd0);
        check_rsp("t4_head_a", 8'h11, 8'h12, CORDIC_MODE_ROT, 1'b0);
        base = start_cnt;
        fork
            begin
                m_out0 = 8'h31; m_out1 = 8'h32;
                send_job(CORDIC_MODE_ROT, 8'h03, 8'h03);
            end
            begin
                wait_cycles(3);
                check_eq("t4_still_blocked", {31'd0, req_ready}, 32'd0);
                check_eq("t4_no_start_when_full", start_cnt - base, 32'd0);
                pop_rsp();
            end
        join
        check_rsp("t4_head_b", 8'h21, 8'h22, CORDIC_MODE_VEC, 1'b0);
        wait_cycles(5);
        check_eq("t4_full_again", {31'd0, req_ready}, 32'd0);
        pop_rsp();
        check_rsp("t4_head_c", 8'h31, 8'h32, CORDIC_MODE_ROT, 1'b0);
        pop_rsp();
        check_eq("t4_drained", {31'd0, rsp_valid}, 32'd0);

        // core never completes: timeout entry, then a normal job
        m_never = 1'b1;
        send_job(CORDIC_MODE_VEC, 8'h33, 8'h44);
        wait_rsp(lat);
        check_eq("t5_tmo_latency", lat, TIMEOUT_CYC + 1);
        check_rsp("t5_tmo", 8'h00, 8'h00, CORDIC_MODE_VEC, 1'b1);
        pop_rsp();
        m_never = 1'b0; m_delay = 3; m_out0 = 8'h77; m_out1 = 8'h66;
        send_job(CORDIC_MODE_ROT, 8'h05, 8'h06);
        wait_rsp(lat);
        check_eq("t5_next_latency", lat, 32'd4);
        check_rsp("t5_next", 8'h77, 8'h66, CORDIC_MODE_ROT, 1'b0);
        pop_rsp();

        // done edge exactly on the timeout cycle wins
        m_delay = TIMEOUT_CYC; m_out0 = 8'hA5; m_out1 = 8'h5A;
        send_job(CORDIC_MODE_ROT, 8'h07, 8'h08);
        wait_rsp(lat);
        check_eq("t6_edge_latency", lat, TIMEOUT_CYC + 1);
        check_rsp("t6_edge", 8'hA5, 8'h5A, CORDIC_MODE_ROT, 1'b0);

        // push and pop in the same cycle with one entry queued
        m_delay = 6; m_out0 = 8'hC3; m_out1 = 8'h3C;
        send_job(CORDIC_MODE_VEC, 8'h09, 8'h0A);
        wait_cycles(6);
        check_eq("t6_head_before", {24'd0, rsp_x}, 32'hA5);
        rsp_ready = 1'b1;
        @(posedge clka);
        #1;
        rsp_ready = 1'b0;
        check_rsp("t6_pushpop", 8'hC3, 8'h3C, CORDIC_MODE_VEC, 1'b0);
        check_eq("t6_ready_count1", {31'd0, req_ready}, 32'd1);
        pop_rsp();
        check_eq("t6_count_was_one", {31'd0, rsp_valid}, 32'd0);

        // reset in the middle of a job with one entry queued
        m_delay = 2; m_out0 = 8'h55; m_out1 = 8'hAA;
        send_job(CORDIC_MODE_ROT, 8'h0B, 8'h0C);
        wait_rsp(lat);
        m_delay = 20;
        send_job(CORDIC_MODE_VEC, 8'h99, 8'h88);
        wait_cycles(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t1_rst_core_start", {31'd0, core_start}, 32'd0);
        check_eq("t1_rst_core_mode", {31'd0, core_mode}, 32'd0);
        check_eq("t1_rst_port0", {24'd0, core_port0}, 32'd0);
        check_eq("t1_rst_port1", {24'd0, core_port1}, 32'd0);
        check_eq("t1_rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("t1_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("t1_rst_rsp_x", {24'd0, rsp_x}, 32'd0);
        check_eq("t1_rst_rsp_y", {24'd0, rsp_y}, 32'd0);
        check_eq("t1_rst_rsp_mode", {31'd0, rsp_mode}, 32'd0);
        check_eq("t1_rst_rsp_tmo", {31'd0, rsp_tmo}, 32'd0);
        @(negedge clka);
        reset_n = 1'b1;
        @(posedge clka);
        #1;
        check_eq("t1_rel_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("t1_rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        wait_cycles(25);
        check_eq("t1_no_late_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("t1_idle_ready", {31'd0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
